// File: rtl/fifo_level_pkg.sv
// Shared constants and the threshold legality check for the fifo_level FIFO.
// Used by fifo_level and its storage sub-module fifo_level_ram.
package fifo_level_pkg;

    localparam int DEF_DATA_SIZE        = 8;
    localparam int DEF_ADDR_SPACE_EXP   = 4;
    localparam int DEF_ALMOST_FULL_LVL  = 14;
    localparam int DEF_ALMOST_EMPTY_LVL = 2;

    function automatic bit thresholds_legal(input int ae_lvl, input int af_lvl, input int depth);
        return (ae_lvl < af_lvl) && (af_lvl <= depth);
    endfunction

endpackage

// File: rtl/fifo_level_ram.sv
// Storage for fifo_level: DATA_SIZE x DEPTH register file with a synchronous
// write port and an asynchronous read port. Contents are never reset.
module fifo_level_ram
    import fifo_level_pkg::*;
#(
    parameter int DATA_SIZE      = DEF_DATA_SIZE,
    parameter int ADDR_SPACE_EXP = DEF_ADDR_SPACE_EXP
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ADDR_SPACE_EXP-1:0] waddr,
    input  logic [DATA_SIZE-1:0]      wdata,
    input  logic [ADDR_SPACE_EXP-1:0] raddr,
    output logic [DATA_SIZE-1:0]      rdata
);

    localparam int DEPTH = 1 << ADDR_SPACE_EXP;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_level.sv
// Show-ahead synchronous FIFO with occupancy count, almost thresholds, error
// flags and synchronous flush. FIFO_STICKY_ERR_EN makes overflow/underflow sticky.
module fifo_level
    import fifo_level_pkg::*;
#(
    parameter int DATA_SIZE        = DEF_DATA_SIZE,
    parameter int ADDR_SPACE_EXP   = DEF_ADDR_SPACE_EXP,
    parameter int ALMOST_FULL_LVL  = DEF_ALMOST_FULL_LVL,
    parameter int ALMOST_EMPTY_LVL = DEF_ALMOST_EMPTY_LVL
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      write_to_fifo,
    input  logic [DATA_SIZE-1:0]      write_data_in,
    input  logic                      read_from_fifo,
    output logic [DATA_SIZE-1:0]      read_data_out,
    output logic [ADDR_SPACE_EXP:0]   count,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int DEPTH   = 1 << ADDR_SPACE_EXP;
    localparam int COUNT_W = ADDR_SPACE_EXP + 1;

    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] AF_LVL  = COUNT_W'(ALMOST_FULL_LVL);
    localparam logic [COUNT_W-1:0] AE_LVL  = COUNT_W'(ALMOST_EMPTY_LVL);

    if (!thresholds_legal(ALMOST_EMPTY_LVL, ALMOST_FULL_LVL, DEPTH)) begin : g_bad_thresholds
        $error("fifo_level: need ALMOST_EMPTY_LVL < ALMOST_FULL_LVL <= DEPTH");
    end

    logic [ADDR_SPACE_EXP-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SPACE_EXP-1:0] rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0]        count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic                      underflow_q, underflow_d;
    logic                      rd_acc, wr_acc, ram_we;
    logic                      ovf_evt, unf_evt;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO is still accepted when a read frees the slot in the same cycle.
    always_comb begin
        rd_acc  = read_from_fifo & ~empty;
        wr_acc  = write_to_fifo & (~full | rd_acc);
        ovf_evt = write_to_fifo & ~wr_acc;
        unf_evt = read_from_fifo & empty;
        ram_we  = wr_acc & ~clear;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
`ifdef FIFO_STICKY_ERR_EN
        overflow_d  = overflow_q | ovf_evt;
        underflow_d = underflow_q | unf_evt;
`else
        overflow_d  = ovf_evt;
        underflow_d = unf_evt;
`endif

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_SPACE_EXP'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_SPACE_EXP'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + COUNT_W'(1);
                2'b01:   count_d = count_q - COUNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_level_ram #(
        .DATA_SIZE      (DATA_SIZE),
        .ADDR_SPACE_EXP (ADDR_SPACE_EXP)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (write_data_in),
        .raddr (rd_ptr_q),
        .rdata (read_data_out)
    );

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level at default parameters (DEPTH 16).
// Expected values are hand-derived; the wrap section keeps a small queue of expected words.
module tb_fifo_level;

`ifdef FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       write_to_fifo;
    logic [7:0] write_data_in;
    logic       read_from_fifo;
    logic [7:0] read_data_out;
    logic [4:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [7:0] q_exp [$];

    fifo_level dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .write_to_fifo  (write_to_fifo),
        .write_data_in  (write_data_in),
        .read_from_fifo (read_from_fifo),
        .read_data_out  (read_data_out),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input int cnt, input bit ovf, input bit unf);
        check({tag, " count"}, 32'(count), 32'(cnt));
        check({tag, " empty"}, 32'(empty), 32'(cnt == 0));
        check({tag, " full"}, 32'(full), 32'(cnt == 16));
        check({tag, " almost_full"}, 32'(almost_full), 32'(cnt >= 14));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
        check({tag, " overflow"}, 32'(overflow), 32'(ovf));
        check({tag, " underflow"}, 32'(underflow), 32'(unf));
    endtask

    initial begin
        reset_n        = 1'b0;
        clear          = 1'b0;
        write_to_fifo  = 1'b0;
        write_data_in  = 8'h00;
        read_from_fifo = 1'b0;
        #12;
        check_flags("reset", 0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            write_to_fifo = 1'b1;
            write_data_in = 8'(i);
            tick();
            check_flags($sformatf("fill%0d", i), i + 1, 1'b0, 1'b0);
            check("fill head", 32'(read_data_out), 32'h00);
        end
        write_data_in = 8'h99;
        tick();
        check_flags("overflow write", 16, 1'b1, 1'b0);
        write_to_fifo = 1'b0;
        tick();
        check("overflow after idle", 32'(overflow), 32'(STICKY));
        check("count after idle", 32'(count), 32'd16);

        // Drain 0x00..0x0F in order, then one read too many.
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain data%0d", i), 32'(read_data_out), 32'(i));
            read_from_fifo = 1'b1;
            tick();
            check_flags($sformatf("drain%0d", i), 15 - i, STICKY, 1'b0);
        end
        tick();
        check_flags("underflow read", 0, STICKY, 1'b1);
        read_from_fifo = 1'b0;

        // Refill, then simultaneous read/write of 0xAA on the full FIFO.
        for (int i = 0; i < 16; i++) begin
            write_to_fifo = 1'b1;
            write_data_in = 8'(i);
            tick();
        end
        check("refill count", 32'(count), 32'd16);
        read_from_fifo = 1'b1;
        write_data_in  = 8'hAA;
        tick();
        check("full rw count", 32'(count), 32'd16);
        check("full rw head", 32'(read_data_out), 32'h01);
        check("full rw overflow", 32'(overflow), 32'(STICKY));
        write_to_fifo = 1'b0;
        for (int i = 1; i < 16; i++) begin
            check($sformatf("post rw data%0d", i), 32'(read_data_out), 32'(i));
            tick();
        end
        check("0xAA emerges", 32'(read_data_out), 32'hAA);
        check("0xAA count", 32'(count), 32'd1);
        tick();
        check("emptied", 32'(empty), 32'd1);

        // Simultaneous read/write on the empty FIFO.
        write_to_fifo = 1'b1;
        write_data_in = 8'h55;
        tick();
        check("empty rw count", 32'(count), 32'd1);
        check("empty rw underflow", 32'(underflow), 32'd1);
        check("empty rw empty", 32'(empty), 32'd0);
        check("empty rw data", 32'(read_data_out), 32'h55);
        read_from_fifo = 1'b0;
        write_to_fifo  = 1'b0;
        tick();
        check("underflow after idle", 32'(underflow), 32'(STICKY));

        // Bring to count 8, then 20 read+write cycles across the pointer wrap.
        q_exp.push_back(8'h55);
        for (int i = 0; i < 7; i++) begin
            write_to_fifo = 1'b1;
            write_data_in = 8'(8'h60 + i);
            q_exp.push_back(write_data_in);
            tick();
        end
        check("count 8", 32'(count), 32'd8);
        read_from_fifo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            write_data_in = 8'(8'h80 + i);
            check($sformatf("wrap data%0d", i), 32'(read_data_out), 32'(q_exp[0]));
            void'(q_exp.pop_front());
            q_exp.push_back(write_data_in);
            tick();
            check($sformatf("wrap count%0d", i), 32'(count), 32'd8);
        end
        write_to_fifo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("trim data%0d", i), 32'(read_data_out), 32'(q_exp[0]));
            void'(q_exp.pop_front());
            tick();
        end
        read_from_fifo = 1'b0;
        check("count 5", 32'(count), 32'd5);

        // Clear with a concurrent write: the write is dropped.
        clear         = 1'b1;
        write_to_fifo = 1'b1;
        write_data_in = 8'hEE;
        tick();
        clear = 1'b0;
        check_flags("clear", 0, 1'b0, 1'b0);
        write_data_in = 8'h33;
        tick();
        write_to_fifo = 1'b0;
        check("post clear data", 32'(read_data_out), 32'h33);
        check("post clear count", 32'(count), 32'd1);

        // Asynchronous reset in the middle of a write burst.
        write_to_fifo = 1'b1;
        for (int i = 0; i < 3; i++) begin
            write_data_in = 8'(8'h40 + i);
            tick();
        end
        check("pre reset count", 32'(count), 32'd4);
        #3;
        reset_n = 1'b0;
        #1;
        check_flags("async reset", 0, 1'b0, 1'b0);
        write_to_fifo = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("after reset count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
